chime_alarm_gen: RTL and testbench

- Hourly pip generator plus multi-channel alarm for the digital clock.
- Compares the clock's BCD time against the hourly-chime pattern and N_ALARM programmable alarm times.
- Drives a speaker with a square wave synthesised from CP: low tone for the pre-hour pips, high tone for the on-the-hour pip and for alarms.
- Sits beside the hour/minute/second counters; consumes their BCD outputs directly.

---
 rtl/chime_alarm_gen.sv | 176 +++++++++++++++++
 tb/tb_chime_alarm_gen.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chime_alarm_gen.sv
// Hourly pip generator and N-channel alarm with square-wave speaker drive.
// Ports: CP/nCR clock+async reset; Hour/Minute/Second BCD time; Chime_En;
//   Alarm_Time/Alarm_En per-channel; Stop; Low_sound/High_sound pips;
//   Alarm_Ring per-channel; Speaker audio.
module chime_alarm_gen #(
   parameter int CLK_HZ     = 4000,
   parameter int LOW_HZ     = 500,
   parameter int HIGH_HZ    = 1000,
   parameter int N_LOW_PIPS = 4,
   parameter int N_ALARM    = 2,
   parameter int ALARM_SECS = 60
) (
   input  logic                   CP,
   input  logic                   nCR,
   input  logic [7:0]             Hour,
   input  logic [7:0]             Minute,
   input  logic [7:0]             Second,
   input  logic                   Chime_En,
   input  logic [16*N_ALARM-1:0]  Alarm_Time,
   input  logic [N_ALARM-1:0]     Alarm_En,
   input  logic                   Stop,
   output logic                   Low_sound,
   output logic                   High_sound,
   output logic [N_ALARM-1:0]     Alarm_Ring,
   output logic                   Speaker
);

   localparam int HALF_LO = CLK_HZ / (2 * LOW_HZ);
   localparam int HALF_HI = CLK_HZ / (2 * HIGH_HZ);
   localparam int PW      = $clog2(CLK_HZ);
   localparam int HW      = 16;

   localparam logic [PW-1:0] PH_MAX  = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(CLK_HZ / 2);
   localparam logic [HW-1:0] LO_TOP  = HW'(HALF_LO - 1);
   localparam logic [HW-1:0] HI_TOP  = HW'(HALF_HI - 1);
   localparam logic [7:0]    SEC_TOP = 8'(ALARM_SECS);

   if (HALF_LO < 1 || HALF_HI < 1 || HALF_LO >= 65536) begin : g_bad_tone
      $error("chime_alarm_gen: tone half-period out of range");
   end
   if (N_LOW_PIPS < 1 || N_LOW_PIPS > 5) begin : g_bad_pips
      $error("chime_alarm_gen: N_LOW_PIPS must be 1..5");
   end
   if (N_ALARM < 1 || N_ALARM > 8) begin : g_bad_nalarm
      $error("chime_alarm_gen: N_ALARM must be 1..8");
   end
   if (ALARM_SECS < 1 || ALARM_SECS > 255) begin : g_bad_secs
      $error("chime_alarm_gen: ALARM_SECS must be 1..255");
   end

   typedef enum logic [1:0] {
      TONE_OFF,
      TONE_LO,
      TONE_HI
   } tone_e;

   logic [7:0]         sec_prev_q, sec_prev_d;
   logic               low_q, low_d;
   logic               high_q, high_d;
   logic [N_ALARM-1:0] ring_q, ring_d;
   logic [7:0]         cnt_q [N_ALARM];
   logic [7:0]         cnt_d [N_ALARM];
   logic [PW-1:0]      phase_q, phase_d;
   tone_e              tone_q, tone_d;
   logic [HW-1:0]      hcnt_q, hcnt_d;
   logic               spk_q, spk_d;

   logic               sec_chg;
   logic               low_hit;
   logic               alarm_on;
   logic [N_ALARM-1:0] trig;
   logic [HW-1:0]      half_top;

   // Low pips sit on the odd seconds 59-2k, matched as literal BCD.
   always_comb begin
      low_hit = 1'b0;
      for (int k = 1; k <= N_LOW_PIPS; k++) begin
         if (Second == {4'((59 - 2 * k) / 10), 4'((59 - 2 * k) % 10)})
            low_hit = 1'b1;
      end
   end

   always_comb begin
      sec_chg    = (Second != sec_prev_q);
      sec_prev_d = Second;
      low_d      = Chime_En && (Minute == 8'h59) && low_hit;
      high_d     = Chime_En && (Minute == 8'h59) && (Second == 8'h59);

      trig   = '0;
      ring_d = ring_q;
      for (int i = 0; i < N_ALARM; i++) begin
         cnt_d[i] = cnt_q[i];
         trig[i]  = sec_chg && (Second == 8'h00) && Alarm_En[i] &&
                    ({Hour, Minute} == Alarm_Time[16*i +: 16]);
         if (Stop || !Alarm_En[i]) begin
            ring_d[i] = 1'b0;
            cnt_d[i]  = 8'd0;
         end else if (trig[i]) begin
            ring_d[i] = 1'b1;
            cnt_d[i]  = 8'd0;
         end else if (ring_q[i]) begin
            if (cnt_q[i] == SEC_TOP) begin
               ring_d[i] = 1'b0;
               cnt_d[i]  = 8'd0;
            end else if (sec_chg) begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end

      // Phase within the current second; saturates so a stalled
      // time base leaves the beep in its off half.
      if (sec_chg)
         phase_d = '0;
      else if (phase_q == PH_MAX)
         phase_d = phase_q;
      else
         phase_d = phase_q + 1'b1;

      alarm_on = (|ring_q) && (phase_q < PH_HALF);

      // Pips take priority over the alarm beep.
      if (high_q)
         tone_d = TONE_HI;
      else if (low_q)
         tone_d = TONE_LO;
      else if (alarm_on)
         tone_d = TONE_HI;
      else
         tone_d = TONE_OFF;

      half_top = (tone_d == TONE_HI) ? HI_TOP : LO_TOP;

      if (tone_d == TONE_OFF || tone_d != tone_q) begin
         hcnt_d = '0;
         spk_d  = 1'b0;
      end else if (hcnt_q == half_top) begin
         hcnt_d = '0;
         spk_d  = ~spk_q;
      end else begin
         hcnt_d = hcnt_q + 1'b1;
         spk_d  = spk_q;
      end
   end

   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         sec_prev_q <= 8'h00;
         low_q      <= 1'b0;
         high_q     <= 1'b0;
         ring_q     <= '0;
         for (int i = 0; i < N_ALARM; i++) cnt_q[i] <= 8'd0;
         phase_q    <= '0;
         tone_q     <= TONE_OFF;
         hcnt_q     <= '0;
         spk_q      <= 1'b0;
      end else begin
         sec_prev_q <= sec_prev_d;
         low_q      <= low_d;
         high_q     <= high_d;
         ring_q     <= ring_d;
         for (int i = 0; i < N_ALARM; i++) cnt_q[i] <= cnt_d[i];
         phase_q    <= phase_d;
         tone_q     <= tone_d;
         hcnt_q     <= hcnt_d;
         spk_q      <= spk_d;
      end
   end

   assign Low_sound  = low_q;
   assign High_sound = high_q;
   assign Alarm_Ring = ring_q;
   assign Speaker    = spk_q;

endmodule

// File: tb/tb_chime_alarm_gen.sv
// Bench for chime_alarm_gen: vector table, directed alarm/pip sequences,
// then random stimulus against a behavioural model.
module tb_chime_alarm_gen;

   localparam int CLK_HZ  = 4000;
   localparam int HALF_LO = CLK_HZ / (2 * 500);
   localparam int HALF_HI = CLK_HZ / (2 * 1000);
   localparam int NA      = 2;
   localparam int ASECS   = 60;
   localparam int NPIPS   = 4;

   logic          CP = 1'b0;
   logic          nCR = 1'b0;
   logic [7:0]    t_hour = 8'h00;
   logic [7:0]    t_min = 8'h00;
   logic [7:0]    t_sec = 8'h00;
   logic          chime = 1'b0;
   logic [16*NA-1:0] atime = '0;
   logic [NA-1:0] aen = '0;
   logic          stop = 1'b0;
   logic          Low_sound, High_sound, Speaker;
   logic [NA-1:0] Alarm_Ring;

   int n_chk = 0;
   int n_fail = 0;

   chime_alarm_gen #(
      .CLK_HZ(CLK_HZ), .LOW_HZ(500), .HIGH_HZ(1000),
      .N_LOW_PIPS(NPIPS), .N_ALARM(NA), .ALARM_SECS(ASECS)
   ) dut (
      .CP(CP), .nCR(nCR), .Hour(t_hour), .Minute(t_min), .Second(t_sec),
      .Chime_En(chime), .Alarm_Time(atime), .Alarm_En(aen), .Stop(stop),
      .Low_sound(Low_sound), .High_sound(High_sound),
      .Alarm_Ring(Alarm_Ring), .Speaker(Speaker)
   );

   always #5 CP = ~CP;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic logic [7:0] bcd(input int v);
      logic [3:0] hi, lo;
      hi = 4'(v / 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   function automatic bit low_set(input logic [7:0] s);
      for (int k = 1; k <= NPIPS; k++)
         if (s == bcd(59 - 2 * k)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CP);
      #1;
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s);
      t_hour = h;
      t_min  = m;
      t_sec  = s;
   endtask

   // Cycles between the first two Speaker rises in a bounded window;
   // 0 when fewer than two rises are seen.
   task automatic meas_period(output int per);
      int f, s;
      logic prev;
      f = -1;
      s = -1;
      prev = Speaker;
      for (int c = 0; c < 48; c++) begin
         @(negedge CP);
         if (Speaker && !prev) begin
            if (f < 0) f = c;
            else if (s < 0) s = c;
         end
         prev = Speaker;
      end
      per = (s >= 0) ? (s - f) : 0;
   endtask

   // Behavioural reference: tone is held for an age in cycles and the
   // speaker level is the parity of age/HALF.
   logic [7:0]    m_prev;
   bit            m_low, m_high, m_spk;
   bit [NA-1:0]   m_ring;
   int            m_secs [NA];
   int            m_phase, m_tone, m_age;

   always @(posedge CP or negedge nCR) begin
      int  tn;
      bit  on, sc, hit;
      if (!nCR) begin
         m_prev = 8'h00;
         m_low = 0;
         m_high = 0;
         m_ring = '0;
         for (int i = 0; i < NA; i++) m_secs[i] = 0;
         m_phase = 0;
         m_tone = 0;
         m_age = 0;
         m_spk = 0;
      end else begin
         on = (m_ring != 0) && (m_phase < CLK_HZ / 2);
         tn = m_high ? 2 : (m_low ? 1 : (on ? 2 : 0));
         if (tn == 0 || tn != m_tone) m_age = 0;
         else m_age = m_age + 1;
         m_spk = (tn != 0) &&
                 (((m_age / ((tn == 2) ? HALF_HI : HALF_LO)) % 2) == 1);
         m_tone = tn;
         sc = (t_sec != m_prev);
         for (int i = 0; i < NA; i++) begin
            hit = sc && t_sec == 8'h00 &&
                  {t_hour, t_min} == atime[16*i +: 16];
            if (stop || !aen[i]) begin
               m_ring[i] = 0;
               m_secs[i] = 0;
            end else if (hit) begin
               m_ring[i] = 1;
               m_secs[i] = 0;
            end else if (m_ring[i]) begin
               if (m_secs[i] == ASECS) begin
                  m_ring[i] = 0;
                  m_secs[i] = 0;
               end else if (sc) begin
                  m_secs[i] = m_secs[i] + 1;
               end
            end
         end
         if (sc) m_phase = 0;
         else if (m_phase < CLK_HZ - 1) m_phase = m_phase + 1;
         m_low  = chime && t_min == 8'h59 && low_set(t_sec);
         m_high = chime && t_min == 8'h59 && t_sec == 8'h59;
         m_prev = t_sec;
      end
   end

   typedef struct {
      logic [7:0] mn;
      logic [7:0] sc;
      logic       ce;
      logic       low;
      logic       high;
      int         per;
   } vec_t;

   vec_t vecs [13];

   initial begin
      int per, hi1, hi2;
      vecs[0]  = '{8'h59, 8'h50, 1'b1, 1'b0, 1'b0, 0};
      vecs[1]  = '{8'h59, 8'h51, 1'b1, 1'b1, 1'b0, 2 * HALF_LO};
      vecs[2]  = '{8'h59, 8'h52, 1'b1, 1'b0, 1'b0, 0};
      vecs[3]  = '{8'h59, 8'h53, 1'b1, 1'b1, 1'b0, 2 * HALF_LO};
      vecs[4]  = '{8'h59, 8'h55, 1'b1, 1'b1, 1'b0, 2 * HALF_LO};
      vecs[5]  = '{8'h59, 8'h57, 1'b1, 1'b1, 1'b0, 2 * HALF_LO};
      vecs[6]  = '{8'h59, 8'h58, 1'b1, 1'b0, 1'b0, 0};
      vecs[7]  = '{8'h59, 8'h59, 1'b1, 1'b0, 1'b1, 2 * HALF_HI};
      vecs[8]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0};
      vecs[9]  = '{8'h58, 8'h51, 1'b1, 1'b0, 1'b0, 0};
      vecs[10] = '{8'h59, 8'h51, 1'b0, 1'b0, 1'b0, 0};
      vecs[11] = '{8'h59, 8'h59, 1'b0, 1'b0, 1'b0, 0};
      vecs[12] = '{8'h59, 8'h49, 1'b1, 1'b0, 1'b0, 0};

      // reset state
      #23;
      chk("rst_low", 32'(Low_sound), 32'd0);
      chk("rst_high", 32'(High_sound), 32'd0);
      chk("rst_ring", 32'(Alarm_Ring), 32'd0);
      chk("rst_spk", 32'(Speaker), 32'd0);
      step(1);
      nCR = 1'b1;

      // one-cycle pip latency
      chime = 1'b1;
      set_time(8'h10, 8'h59, 8'h50);
      step(3);
      t_sec = 8'h51;
      @(negedge CP);
      chk("lat_pre", 32'(Low_sound), 32'd0);
      step(1);
      @(negedge CP);
      chk("lat_post", 32'(Low_sound), 32'd1);

      // pip table
      for (int v = 0; v < 13; v++) begin
         set_time(8'h10, vecs[v].mn, vecs[v].sc);
         chime = vecs[v].ce;
         step(3);
         @(negedge CP);
         chk($sformatf("vec%0d_low", v), 32'(Low_sound), 32'(vecs[v].low));
         chk($sformatf("vec%0d_high", v), 32'(High_sound),
             32'(vecs[v].high));
         meas_period(per);
         chk($sformatf("vec%0d_period", v), 32'(per), 32'(vecs[v].per));
      end
      chk("vec_end_spk", 32'(Speaker), 32'd0);

      // single alarm: beep shape and auto clear
      chime = 1'b0;
      atime = {8'h08, 8'h00, 8'h07, 8'h30};
      aen = 2'b01;
      set_time(8'h07, 8'h29, 8'h59);
      step(3);
      set_time(8'h07, 8'h30, 8'h00);
      @(negedge CP);
      chk("a_pre", 32'(Alarm_Ring), 32'd0);
      step(1);
      @(negedge CP);
      chk("a_ring", 32'(Alarm_Ring), 32'd1);
      hi1 = 0;
      hi2 = 0;
      for (int c = 1; c <= CLK_HZ; c++) begin
         @(negedge CP);
         if (Speaker) begin
            if (c <= CLK_HZ / 2) hi1++;
            else hi2++;
         end
      end
      chk("a_beep_on", 32'(hi1 >= 995 && hi1 <= 1000), 32'd1);
      chk("a_beep_off", 32'(hi2), 32'd0);
      for (int s = 1; s <= 59; s++) begin
         t_sec = bcd(s);
         step(5);
      end
      @(negedge CP);
      chk("a_ring59", 32'(Alarm_Ring), 32'd1);
      set_time(8'h07, 8'h31, 8'h00);
      step(1);
      @(negedge CP);
      chk("a_ring60", 32'(Alarm_Ring), 32'd1);
      step(1);
      @(negedge CP);
      chk("a_autoclr", 32'(Alarm_Ring), 32'd0);

      // two channels, Stop
      atime = {8'h08, 8'h00, 8'h08, 8'h00};
      aen = 2'b11;
      set_time(8'h07, 8'h59, 8'h59);
      step(3);
      set_time(8'h08, 8'h00, 8'h00);
      step(1);
      @(negedge CP);
      chk("b_ring", 32'(Alarm_Ring), 32'd3);
      for (int s = 1; s <= 12; s++) begin
         t_sec = bcd(s);
         step(5);
      end
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      @(negedge CP);
      chk("b_stop", 32'(Alarm_Ring), 32'd0);
      step(3);
      @(negedge CP);
      chk("b_spk", 32'(Speaker), 32'd0);
      t_sec = 8'h59;
      step(3);
      t_sec = 8'h00;
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      @(negedge CP);
      chk("b_stopwins", 32'(Alarm_Ring), 32'd0);
      step(2);
      @(negedge CP);
      chk("b_stay", 32'(Alarm_Ring), 32'd0);

      // pips override a ringing alarm
      atime = {8'h08, 8'h00, 8'h09, 8'h59};
      aen = 2'b01;
      chime = 1'b1;
      set_time(8'h09, 8'h58, 8'h59);
      step(3);
      set_time(8'h09, 8'h59, 8'h00);
      step(1);
      @(negedge CP);
      chk("c_ring", 32'(Alarm_Ring), 32'd1);
      t_sec = 8'h50;
      step(3);
      t_sec = 8'h51;
      step(3);
      @(negedge CP);
      chk("c_low", 32'(Low_sound), 32'd1);
      chk("c_ring51", 32'(Alarm_Ring), 32'd1);
      meas_period(per);
      chk("c_low_per", 32'(per), 32'(2 * HALF_LO));
      t_sec = 8'h52;
      step(3);
      meas_period(per);
      chk("c_beep52_per", 32'(per), 32'(2 * HALF_HI));
      t_sec = 8'h59;
      step(3);
      @(negedge CP);
      chk("c_high", 32'(High_sound), 32'd1);
      chk("c_ring59", 32'(Alarm_Ring), 32'd1);
      set_time(8'h10, 8'h00, 8'h00);
      step(3);
      @(negedge CP);
      chk("c_hr_high", 32'(High_sound), 32'd0);
      chk("c_hr_low", 32'(Low_sound), 32'd0);
      chk("c_hr_ring", 32'(Alarm_Ring), 32'd1);
      meas_period(per);
      chk("c_resume_per", 32'(per), 32'(2 * HALF_HI));
      aen = 2'b00;
      step(1);
      @(negedge CP);
      chk("c_en_clr", 32'(Alarm_Ring), 32'd0);

      // asynchronous reset mid-pip while ringing
      atime = {8'h08, 8'h00, 8'h10, 8'h59};
      aen = 2'b01;
      set_time(8'h10, 8'h58, 8'h59);
      step(3);
      set_time(8'h10, 8'h59, 8'h00);
      step(1);
      t_sec = 8'h59;
      step(3);
      @(negedge CP);
      chk("r_high", 32'(High_sound), 32'd1);
      chk("r_ring", 32'(Alarm_Ring), 32'd1);
      #1 nCR = 1'b0;
      #1;
      chk("r_async_high", 32'(High_sound), 32'd0);
      chk("r_async_low", 32'(Low_sound), 32'd0);
      chk("r_async_ring", 32'(Alarm_Ring), 32'd0);
      chk("r_async_spk", 32'(Speaker), 32'd0);
      step(2);
      nCR = 1'b1;
      chime = 1'b0;
      t_sec = 8'h58;
      step(5);
      @(negedge CP);
      chk("r_noresume", 32'(Alarm_Ring), 32'd0);
      chk("r_spk", 32'(Speaker), 32'd0);

      // random stimulus against the model
      atime = {8'h08, 8'h59, 8'h07, 8'h30};
      aen = 2'b11;
      chime = 1'b1;
      set_time(8'h07, 8'h30, 8'h10);
      for (int c = 0; c < 8000; c++) begin
         @(negedge CP);
         chk("rnd_low", 32'(Low_sound), 32'(m_low));
         chk("rnd_high", 32'(High_sound), 32'(m_high));
         chk("rnd_ring", 32'(Alarm_Ring), 32'(m_ring));
         chk("rnd_spk", 32'(Speaker), 32'(m_spk));
         stop = 1'b0;
         if ($urandom_range(11) == 0) begin
            case ($urandom_range(5))
               0: t_sec = 8'h00;
               1: t_sec = 8'h51;
               2: t_sec = 8'h59;
               3: t_sec = 8'h57;
               4: t_sec = 8'h52;
               default: t_sec = bcd($urandom_range(59));
            endcase
         end
         if ($urandom_range(39) == 0) begin
            t_hour = ($urandom_range(1) == 0) ? 8'h07 : 8'h08;
            case ($urandom_range(3))
               0: t_min = 8'h30;
               1: t_min = 8'h59;
               2: t_min = 8'h00;
               default: t_min = 8'h31;
            endcase
         end
         if ($urandom_range(99) == 0) chime = ~chime;
         if ($urandom_range(149) == 0) aen = NA'($urandom_range(3));
         if ($urandom_range(299) == 0) stop = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
